// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// pll_lock_sequencer
// PLL bring-up sequencer with lock qualification, retry and fault handling.
// Revision: 1.0
// ============================================================================
module pll_lock_sequencer #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_STABLE  = 64,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int MAX_RETRY    = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [1:0] retry_cnt,
    output logic [7:0] relock_cnt,
    output logic [2:0] state
);

    localparam int MAX_A   = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
    localparam int CNT_MAX = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] C_RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_STB_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] C_TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [2:0]       C_MAX_RETRY = 3'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
        S_RUN    = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       retry_q, retry_d;
    logic [7:0]       relock_q, relock_d;
    logic             sync1_q, lock_s_q;
    logic             pll_rst_q, sys_rst_q, ready_q, fault_q;

    always_comb begin
        state_d  = state_q;
        retry_d  = retry_q;
        relock_d = relock_q;
        case (state_q)
            S_RESET: begin
                if (cnt_q == C_RST_LAST) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lock_s_q) begin
                    state_d = S_STABLE;
                end else if (cnt_q == C_TMO_LAST) begin
                    retry_d = retry_q + 2'd1;
                    state_d = (({1'b0, retry_q} + 3'd1) == C_MAX_RETRY) ? S_FAULT : S_RESET;
                end
            end
            S_STABLE: begin
                // Any drop of lock restarts qualification from WAIT_LOCK.
                if (!lock_s_q) begin
                    state_d = S_WAIT;
                end else if (cnt_q == C_STB_LAST) begin
                    state_d = S_RUN;
                    retry_d = 2'd0;
                end
            end
            S_RUN: begin
                if (!lock_s_q) begin
                    state_d = S_RESET;
                    if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
        cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
    end

    // Outputs decode the next state so they line up with the state register.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= S_RESET;
            cnt_q     <= '0;
            retry_q   <= 2'd0;
            relock_q  <= 8'd0;
            sync1_q   <= 1'b0;
            lock_s_q  <= 1'b0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            relock_q  <= relock_d;
            sync1_q   <= pll_locked;
            lock_s_q  <= sync1_q;
            pll_rst_q <= (state_d == S_RESET) || (state_d == S_FAULT);
            sys_rst_q <= (state_d != S_RUN);
            ready_q   <= (state_d == S_RUN);
            fault_q   <= (state_d == S_FAULT);
        end
    end

    assign pll_rst    = pll_rst_q;
    assign sys_rst    = sys_rst_q;
    assign ready      = ready_q;
    assign fault      = fault_q;
    assign retry_cnt  = retry_q;
    assign relock_cnt = relock_q;
    assign state      = state_q;

endmodule
`default_nettype wire

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 Parameter RST_CYCLES, default 16: number of cycles pll_rst is held high on each entry to RESET.
REQ-002 Parameter LOCK_STABLE, default 64: number of consecutive synchronized-lock cycles required before RUN.
REQ-003 Parameter LOCK_TIMEOUT, default 4096: maximum number of WAIT_LOCK cycles without lock before a retry.
REQ-004 Parameter MAX_RETRY, default 3: number of timeouts tolerated before FAULT; range 1..3.
REQ-005 Port refclk  in  1: single clock; all flops on its rising edge.
REQ-006 Port rst  in  1: reset, synchronous, active-high.
REQ-007 Port pll_locked  in  1: PLL lock indicator, asynchronous to refclk.
REQ-008 Port pll_rst  out  1: reset to the PLL, active-high.
REQ-009 Port sys_rst  out  1: downstream datapath reset, active-high.
REQ-010 Port ready  out  1: high only while in RUN.
REQ-011 Port fault  out  1: high only while in FAULT.
REQ-012 Port retry_cnt  out  2: number of lock timeouts since the last RUN entry or rst.
REQ-013 Port relock_cnt  out  8: number of lock losses observed in RUN; saturates at 255.
REQ-014 Port state  out  3: state code; RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4.

Function
REQ-015 pll_locked shall pass through a 2-flop synchronizer; lock_s is the second flop, giving 2 cycles of latency.
REQ-016 A single cycle counter shall be cleared on every state change and shall increment every cycle otherwise.
REQ-017 In RESET, the block shall go to WAIT_LOCK when the counter equals RST_CYCLES-1, so pll_rst stays high for exactly RST_CYCLES cycles.
REQ-018 In WAIT_LOCK with lock_s=1, the block shall go to STABLE.
REQ-019 In WAIT_LOCK with lock_s=0 and the counter equal to LOCK_TIMEOUT-1, a timeout shall occur.
  - If retry_cnt+1 equals MAX_RETRY: go to FAULT.
  - Otherwise: go to RESET.
  - In both cases retry_cnt shall increment.
REQ-020 In STABLE with lock_s=0, the block shall go to WAIT_LOCK; the timeout window restarts from 0 and retry_cnt is unchanged.
REQ-021 In STABLE with lock_s=1 and the counter equal to LOCK_STABLE-1, the block shall go to RUN.
REQ-022 On entry to RUN, retry_cnt shall clear to 0.
REQ-023 In RUN with lock_s=0, the block shall go to RESET and increment relock_cnt, saturating at 255.
REQ-024 FAULT shall be terminal; only rst exits it.
REQ-025 Outputs shall be registered Moore decodes of the state, valid in the same cycle as state:
  - pll_rst=1 in RESET and FAULT.
  - sys_rst=0 only in RUN.
  - ready=1 only in RUN.
  - fault=1 only in FAULT.
REQ-026 sys_rst shall rise in the same cycle that ready falls; sys_rst and ready shall never both be 0.
REQ-027 A lock glitch of any length during STABLE shall restart the stable count; lock shall never be accepted without LOCK_STABLE consecutive lock_s=1 cycles.

Reset
REQ-028 While rst=1, the following shall hold; all are valid in the cycle after rst is sampled high:
  - state=RESET, counter=0, synchronizer flops=0.
  - pll_rst=1, sys_rst=1, ready=0, fault=0.
  - retry_cnt=0, relock_cnt=0.
REQ-029 rst asserted in any state, including RUN and FAULT, shall override all transitions.
REQ-030 The RST_CYCLES count shall begin on the first cycle with rst=0.

Verification (RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, MAX_RETRY=2)
REQ-031 Nominal bring-up: rst released at cycle 0, pll_locked=1 from cycle 10 -> required response:
  - pll_rst=1 for cycles 0-3, WAIT_LOCK at cycle 4.
  - lock_s=1 at cycle 12, STABLE at cycle 13.
  - RUN at cycle 21, with ready=1 and sys_rst=0.
REQ-032 Lock glitch: pll_locked drops for 1 cycle 5 cycles into STABLE -> return to WAIT_LOCK, then STABLE re-entered; RUN only after 8 further consecutive lock cycles; retry_cnt stays 0.
REQ-033 Retry then fault: pll_locked held 0 -> required response:
  - Timeout after 32 WAIT_LOCK cycles: retry_cnt=1, RESET for 4 cycles.
  - Second timeout: retry_cnt=2, FAULT with fault=1, pll_rst=1, sys_rst=1.
  - Block stays in FAULT even if pll_locked later rises.
REQ-034 Loss of lock in RUN: pll_locked falls -> required response:
  - Exactly 3 cycles later: state=RESET, ready=0, sys_rst=1, relock_cnt=1.
  - Normal re-sequence follows, and retry_cnt is 0 on re-entry to RUN.
REQ-035 Mid-operation reset: rst pulsed for 1 cycle during STABLE and again during FAULT -> required response:
  - Each pulse gives state=RESET, all counters 0, all outputs at their reset values.
  - pll_rst is held for a full 4 cycles after rst falls.
REQ-036 Saturation: force 256 lock losses in RUN -> relock_cnt=255 and does not wrap.
